security_alarm_ctrl: RTL and testbench

- Central sequencer for the home-security subsystem.
- Aggregates NUM_WIN window shatter sensors and one door contact.
- Runs arm / exit-delay / armed / entry-delay / alarm sequencing and validates a keypad disarm code.
- Drives the siren, latches which window zones tripped, and sits between the sensor modules and the top-level alarm outputs.

---
 rtl/security_alarm_ctrl_pkg.sv | 40 ++++
 rtl/security_alarm_ctrl_delay_timer.sv | 31 +++
 rtl/security_alarm_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_security_alarm_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/security_alarm_ctrl_pkg.sv
// Shared types and constants for the home-security sequencer.
// Holds the state encoding (also driven out on state_o for LEDs), the
// keypad defaults, and the timer-width helper used by the top level.
package security_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } alarm_state_e;

  localparam int CODE_W_DEF  = 4;
  localparam int MAX_BAD_DEF = 3;

  // Width of the shared down-counter: clog2 of the longest delay.
  // The largest value ever loaded is (delay - 1), so clog2(delay) bits suffice.
  // The result is never allowed to drop below one bit.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    if (m < 2) begin
      return 1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage

// File: rtl/security_alarm_ctrl_delay_timer.sv
// Loadable down-counter shared by the exit, entry and siren delays.
// load has priority; otherwise the count decrements and parks at zero,
// so it can never underflow. done is high whenever the count is zero.
module delay_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Count register: reload, decrement toward zero, or hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/security_alarm_ctrl.sv
// Home-security sequencer: arm / exit delay / armed / entry delay / alarm,
// keypad disarm validation with a wrong-code lockout, siren drive and a
// sticky record of tripped window zones. All outputs are registered.
// Optional build macro WINDOW_24H_EN makes the windows 24-hour zones: a
// shatter while disarmed or in exit delay also raises the alarm, and an
// alarm raised from DISARMED auto-returns to DISARMED instead of ARMED.
module security_alarm_ctrl
  import security_pkg::*;
#(
  parameter int                NUM_WIN     = 4,
  parameter int                EXIT_CYC    = 16,
  parameter int                ENTRY_CYC   = 8,
  parameter int                SIREN_CYC   = 32,
  parameter int                CODE_W      = CODE_W_DEF,
  parameter logic [CODE_W-1:0] DISARM_CODE = CODE_W'(4'hA),
  parameter int                MAX_BAD     = MAX_BAD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               code_valid,
  input  logic [CODE_W-1:0]  code,
  input  logic [NUM_WIN-1:0] shatter,
  input  logic               door_open,
  output logic               siren,
  output logic               armed,
  output logic [NUM_WIN-1:0] zone_latch,
  output logic [2:0]         state_o
);

  localparam int TMR_W = tmr_width(EXIT_CYC, ENTRY_CYC, SIREN_CYC);
  localparam int BAD_W = $clog2(MAX_BAD + 1);

  localparam logic [TMR_W-1:0] EXIT_LOAD  = TMR_W'(EXIT_CYC - 1);
  localparam logic [TMR_W-1:0] ENTRY_LOAD = TMR_W'(ENTRY_CYC - 1);
  localparam logic [TMR_W-1:0] SIREN_LOAD = TMR_W'(SIREN_CYC - 1);
  localparam logic [BAD_W-1:0] BAD_LIMIT  = BAD_W'(MAX_BAD);

  alarm_state_e       state_r, state_s;
  logic [BAD_W-1:0]   bad_r, bad_s;
  logic [NUM_WIN-1:0] zone_r, zone_s;
  logic               origin_r, origin_s;
  logic               siren_r, armed_r;

  logic               tmr_load_s;
  logic [TMR_W-1:0]   tmr_val_s;
  logic               tmr_done_s;

  logic               shatter_any_s;
  logic               code_ok_s;
  logic               code_bad_s;
  logic [BAD_W-1:0]   bad_inc_s;
  logic [BAD_W-1:0]   bad_eff_s;
  logic               bad_trip_s;
  logic               win24_hit_s;
  logic [NUM_WIN-1:0] win24_bits_s;

  delay_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  assign shatter_any_s = |shatter;
  assign code_ok_s     = code_valid & (code == DISARM_CODE);
  assign code_bad_s    = code_valid & (code != DISARM_CODE);
  // Wrong-code counter saturates at the lockout limit.
  assign bad_inc_s     = (bad_r == BAD_LIMIT) ? bad_r : (bad_r + BAD_W'(1));
  assign bad_eff_s     = code_bad_s ? bad_inc_s : bad_r;
  assign bad_trip_s    = (bad_eff_s == BAD_LIMIT);

  // Windows only count while disarmed / in exit delay as 24-hour zones.
  // Without the feature the origin flag can never set and folds away.
`ifdef WINDOW_24H_EN
  assign win24_hit_s  = shatter_any_s;
  assign win24_bits_s = shatter;
`else
  assign win24_hit_s  = 1'b0;
  assign win24_bits_s = '0;
`endif

  // Next-state, counter bookkeeping and timer load decisions.
  always_comb begin
    state_s    = state_r;
    bad_s      = bad_r;
    zone_s     = zone_r;
    origin_s   = origin_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;

    if (code_ok_s && (state_r != ST_DISARMED)) begin
      // A valid code beats every simultaneous sensor, lockout or timeout.
      state_s = ST_DISARMED;
      zone_s  = '0;
      bad_s   = '0;
    end else begin
      case (state_r)
        ST_DISARMED: begin
          bad_s = '0;
          if (win24_hit_s) begin
            state_s    = ST_ALARM;
            zone_s     = zone_r | win24_bits_s;
            origin_s   = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = SIREN_LOAD;
          end else if (arm) begin
            state_s    = ST_EXIT_DELAY;
            tmr_load_s = 1'b1;
            tmr_val_s  = EXIT_LOAD;
          end else begin
            state_s = ST_DISARMED;
          end
        end

        ST_EXIT_DELAY: begin
          bad_s = bad_trip_s ? '0 : bad_eff_s;
          if (bad_trip_s || win24_hit_s) begin
            state_s    = ST_ALARM;
            zone_s     = zone_r | win24_bits_s;
            origin_s   = 1'b0;
            tmr_load_s = 1'b1;
            tmr_val_s  = SIREN_LOAD;
          end else if (tmr_done_s) begin
            state_s = ST_ARMED;
          end else begin
            state_s = ST_EXIT_DELAY;
          end
        end

        ST_ARMED: begin
          bad_s = bad_trip_s ? '0 : bad_eff_s;
          if (shatter_any_s || bad_trip_s) begin
            // Alarm beats a simultaneous door opening.
            state_s    = ST_ALARM;
            zone_s     = zone_r | shatter;
            origin_s   = 1'b0;
            tmr_load_s = 1'b1;
            tmr_val_s  = SIREN_LOAD;
          end else if (door_open) begin
            state_s    = ST_ENTRY_DELAY;
            tmr_load_s = 1'b1;
            tmr_val_s  = ENTRY_LOAD;
          end else begin
            state_s = ST_ARMED;
          end
        end

        ST_ENTRY_DELAY: begin
          bad_s = bad_trip_s ? '0 : bad_eff_s;
          if (shatter_any_s || bad_trip_s || tmr_done_s) begin
            state_s    = ST_ALARM;
            zone_s     = zone_r | shatter;
            origin_s   = 1'b0;
            tmr_load_s = 1'b1;
            tmr_val_s  = SIREN_LOAD;
          end else begin
            state_s = ST_ENTRY_DELAY;
          end
        end

        ST_ALARM: begin
          // Late shatters are recorded but never restart the siren window.
          bad_s  = bad_eff_s;
          zone_s = zone_r | shatter;
          if (tmr_done_s) begin
            state_s = origin_r ? ST_DISARMED : ST_ARMED;
          end else begin
            state_s = ST_ALARM;
          end
        end

        default: begin
          state_s = ST_DISARMED;
          bad_s   = '0;
          zone_s  = '0;
        end
      endcase
    end

    // States that do not time anything park the shared counter at zero.
    if ((state_s == ST_DISARMED) || (state_s == ST_ARMED)) begin
      tmr_load_s = 1'b1;
      tmr_val_s  = '0;
    end else begin
      tmr_load_s = tmr_load_s;
      tmr_val_s  = tmr_val_s;
    end
  end

  // State, bookkeeping and registered output drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_DISARMED;
      bad_r    <= '0;
      zone_r   <= '0;
      origin_r <= 1'b0;
      siren_r  <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      bad_r    <= bad_s;
      zone_r   <= zone_s;
      origin_r <= origin_s;
      siren_r  <= (state_s == ST_ALARM);
      armed_r  <= (state_s == ST_ARMED) || (state_s == ST_ENTRY_DELAY);
    end
  end

  assign siren      = siren_r;
  assign armed      = armed_r;
  assign zone_latch = zone_r;
  assign state_o    = state_r;

endmodule

// File: tb/tb_security_alarm_ctrl.sv
// Self-checking bench for security_alarm_ctrl: directed walk through the
// main sequences, then randomized stimulus checked every cycle against a
// behavioural model that tracks time-in-state rather than a down-counter.
module tb_security_alarm_ctrl;

  localparam int EXIT_CYC  = 16;
  localparam int ENTRY_CYC = 8;
  localparam int SIREN_CYC = 32;
  localparam int MAX_BAD   = 3;
  localparam logic [3:0] GOOD = 4'hA;
`ifdef WINDOW_24H_EN
  localparam bit W24 = 1'b1;
`else
  localparam bit W24 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, arm, code_valid, door_open;
  logic [3:0] code, shatter;
  logic       siren, armed;
  logic [3:0] zone_latch;
  logic [2:0] state_o;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: 0 disarmed, 1 exit, 2 armed, 3 entry, 4 alarm
  int         m_state = 0;
  int         m_age   = 0;
  int         m_bad   = 0;
  logic [3:0] m_zone  = 4'h0;
  bit         m_org   = 1'b0;

  security_alarm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .code_valid (code_valid),
    .code       (code),
    .shatter    (shatter),
    .door_open  (door_open),
    .siren      (siren),
    .armed      (armed),
    .zone_latch (zone_latch),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic enter_alarm(input logic [3:0] bits, input bit org);
    m_state = 4;
    m_age   = 0;
    m_zone  = m_zone | bits;
    m_org   = org;
  endtask

  // One clock of the reference behaviour, applied at the active edge.
  task automatic model_step(input logic r, input logic a, input logic cv,
                            input logic [3:0] c, input logic [3:0] sh, input logic dr);
    bit good, wrong, hit, trip;
    good  = cv && (c == GOOD);
    wrong = cv && (c != GOOD);
    hit   = (sh != 4'h0);
    if (r) begin
      m_state = 0; m_age = 0; m_bad = 0; m_zone = 4'h0; m_org = 1'b0;
    end else if (m_state != 0 && good) begin
      m_state = 0; m_age = 0; m_bad = 0; m_zone = 4'h0;
    end else if (m_state == 0) begin
      m_bad = 0;
      if (W24 && hit) enter_alarm(sh, 1'b1);
      else if (a) begin m_state = 1; m_age = 0; end
    end else begin
      if (wrong && m_bad < MAX_BAD) m_bad++;
      trip = (m_bad == MAX_BAD) && (m_state != 4);
      if (trip) m_bad = 0;
      case (m_state)
        1: if (trip || (W24 && hit)) enter_alarm(W24 ? sh : 4'h0, 1'b0);
           else if (m_age == EXIT_CYC - 1) begin m_state = 2; m_age = 0; end
           else m_age++;
        2: if (trip || hit) enter_alarm(sh, 1'b0);
           else if (dr) begin m_state = 3; m_age = 0; end
        3: if (trip || hit) enter_alarm(sh, 1'b0);
           else if (m_age == ENTRY_CYC - 1) enter_alarm(4'h0, 1'b0);
           else m_age++;
        4: begin
             m_zone = m_zone | sh;
             if (m_age == SIREN_CYC - 1) begin
               m_state = (W24 && m_org) ? 0 : 2;
               m_age   = 0;
             end else m_age++;
           end
        default: m_state = 0;
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare outputs.
  task automatic step(input logic r, input logic a, input logic cv,
                      input logic [3:0] c, input logic [3:0] sh, input logic dr);
    @(negedge clk);
    rst = r; arm = a; code_valid = cv; code = c; shatter = sh; door_open = dr;
    @(posedge clk);
    model_step(r, a, cv, c, sh, dr);
    #1;
    chk("state_o", state_o, m_state);
    chk("siren", siren, (m_state == 4));
    chk("armed", armed, (m_state == 2 || m_state == 3));
    chk("zone_latch", zone_latch, m_zone);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic arm_up();
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    idle(EXIT_CYC);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; code_valid = 1'b0; code = 4'h0; shatter = 4'h0; door_open = 1'b0;

    // reset, then arm through the exit delay
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("reset_state", state_o, 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    idle(EXIT_CYC - 1);
    chk("exit_last", state_o, 32'd1);
    idle(1);
    chk("armed_state", state_o, 32'd2);
    chk("armed_flag", armed, 32'd1);

    // window shatter, siren window, auto re-arm keeps the zone
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'b0100, 1'b0);
    chk("alarm_state", state_o, 32'd4);
    chk("alarm_zone", zone_latch, 32'h4);
    idle(SIREN_CYC);
    chk("rearm_state", state_o, 32'd2);
    chk("rearm_siren", siren, 32'd0);
    chk("rearm_zone", zone_latch, 32'h4);

    // door with no code runs out the entry delay
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(ENTRY_CYC - 1);
    chk("entry_last", state_o, 32'd3);
    idle(1);
    chk("entry_expire", state_o, 32'd4);
    step(1'b0, 1'b0, 1'b1, GOOD, 4'h0, 1'b0);
    chk("alarm_disarm", state_o, 32'd0);

    // correct code during entry delay
    arm_up();
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b1, GOOD, 4'h0, 1'b0);
    chk("entry_code_state", state_o, 32'd0);
    chk("entry_code_zone", zone_latch, 32'h0);

    // three wrong codes force alarm
    arm_up();
    step(1'b0, 1'b0, 1'b1, 4'h3, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h3, 4'h0, 1'b0);
    chk("bad2_state", state_o, 32'd2);
    step(1'b0, 1'b0, 1'b1, 4'h3, 4'h0, 1'b0);
    chk("bad3_state", state_o, 32'd4);
    step(1'b0, 1'b0, 1'b1, GOOD, 4'h0, 1'b0);
    chk("bad_disarm", state_o, 32'd0);

    // code wins over a simultaneous shatter
    arm_up();
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, GOOD, 4'b0001, 1'b0);
    chk("code_vs_shatter", state_o, 32'd0);
    chk("code_vs_siren", siren, 32'd0);

`ifdef WINDOW_24H_EN
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 1'b0);
    chk("w24_alarm", state_o, 32'd4);
    idle(SIREN_CYC);
    chk("w24_return", state_o, 32'd0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic       r, a, cv, dr;
      logic [3:0] c, sh;
      r  = ($urandom_range(0, 399) == 0);
      a  = ($urandom_range(0, 9) == 0);
      cv = ($urandom_range(0, 15) == 0);
      c  = ($urandom_range(0, 2) == 0) ? GOOD : 4'($urandom_range(0, 15));
      sh = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      dr = ($urandom_range(0, 11) == 0);
      step(r, a, cv, c, sh, dr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
